// File: rtl/hqm_rcfwl_gclk_sync_pkg.sv
// Shared types and constants for the gclk PLL sync receiver.
package hqm_rcfwl_gclk_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } sync_state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

endpackage

// File: rtl/hqm_rcfwl_gclk_sync_edge.sv
// Two-flop sampler of the distributed pll_sync level with single-pulse rise detect.
module hqm_rcfwl_gclk_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pll_sync_in,
  output logic rise
);

  logic d1;
  logic d2;

  // Sample the level twice; reset clears both so a level held high
  // through reset release still yields one rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= pll_sync_in;
      d2 <= d1;
    end
  end

  assign rise = d1 & ~d2;

endmodule

// File: rtl/hqm_rcfwl_gclk_pll_sync_rcvr.sv
// Leaf receiver for the mesh-distributed PLL sync pulse: phase counter,
// lock qualification and misalignment reporting.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | disabled; phase held 0
// ST_ACQ    | waiting for first rise; phase held 0
// ST_TRACK  | counting phase, qualifying consecutive on-time pulses
// ST_LOCKED | aligned; early or missed pulses are errors
module hqm_rcfwl_gclk_pll_sync_rcvr
  import hqm_rcfwl_gclk_sync_pkg::*;
#(
  parameter int PERIOD   = 8,
  parameter int CNT_W    = 3,
  parameter int LOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_sync_in,
  input  logic                 sync_en,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     phase_cnt,
  output logic                 phase0,
  output logic                 locked,
  output logic                 sync_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CNT_W-1:0]  END_PH    = CNT_W'(PERIOD - 1);
  localparam logic [GOOD_W-1:0] LAST_GOOD = GOOD_W'(LOCK_CNT - 1);

  sync_state_t          state;
  sync_state_t          state_nxt;
  logic [CNT_W-1:0]     phase_nxt;
  logic [CNT_W-1:0]     phase_inc;
  logic [GOOD_W-1:0]    good_cnt;
  logic [GOOD_W-1:0]    good_nxt;
  logic                 rise;
  logic                 end_ph;
  logic                 err_evt;
  logic                 sync_err_nxt;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;

  hqm_rcfwl_gclk_sync_edge u_edge (
    .clk         (clk),
    .rst         (rst),
    .pll_sync_in (pll_sync_in),
    .rise        (rise)
  );

  assign end_ph    = (phase_cnt == END_PH);
  assign phase_inc = end_ph ? '0 : phase_cnt + 1'b1;

  // Next-state, phase and good-pulse qualification.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    good_nxt  = good_cnt;
    err_evt   = 1'b0;
    if (!sync_en) begin
      state_nxt = ST_IDLE;
      phase_nxt = '0;
      good_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          phase_nxt = '0;
          good_nxt  = '0;
          state_nxt = ST_ACQ;
        end
        ST_ACQ: begin
          phase_nxt = '0;
          if (rise) begin
            good_nxt  = '0;
            state_nxt = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (rise) begin
            phase_nxt = '0;
            if (end_ph) begin
              if (good_cnt == LAST_GOOD) begin
                good_nxt  = '0;
                state_nxt = ST_LOCKED;
              end else begin
                good_nxt = good_cnt + 1'b1;
              end
            end else begin
              good_nxt = '0;
            end
          end else begin
            phase_nxt = phase_inc;
            if (end_ph) good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (rise) begin
            phase_nxt = '0;
            if (!end_ph) begin
              err_evt   = 1'b1;
              good_nxt  = '0;
              state_nxt = ST_TRACK;
            end
          end else begin
            phase_nxt = phase_inc;
            if (end_ph) begin
              err_evt   = 1'b1;
              good_nxt  = '0;
              state_nxt = ST_TRACK;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          phase_nxt = '0;
          good_nxt  = '0;
        end
      endcase
    end
  end

  // Error flag and saturating counter; a same-cycle error beats err_clr.
  always_comb begin
    sync_err_nxt = sync_err;
    err_cnt_nxt  = err_cnt;
    if (err_evt) begin
      sync_err_nxt = 1'b1;
      if (err_clr)                    err_cnt_nxt = ERR_CNT_W'(1);
      else if (err_cnt != ERR_CNT_MAX) err_cnt_nxt = err_cnt + 1'b1;
    end else if (err_clr) begin
      sync_err_nxt = 1'b0;
      err_cnt_nxt  = '0;
    end
  end

  // FSM, phase and qualification registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      good_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      good_cnt  <= good_nxt;
    end
  end

  // Error reporting registers; survive sync_en deassertion.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      sync_err <= sync_err_nxt;
      err_cnt  <= err_cnt_nxt;
    end
  end

  assign locked = (state == ST_LOCKED);
  assign phase0 = (phase_cnt == '0) && ((state == ST_TRACK) || (state == ST_LOCKED));

endmodule

// File: tb/tb_hqm_rcfwl_gclk_pll_sync_rcvr.sv
// Directed bench for the PLL sync receiver (PERIOD=8, LOCK_CNT=4).
module tb_hqm_rcfwl_gclk_pll_sync_rcvr;
  import hqm_rcfwl_gclk_sync_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_sync_in = 1'b0;
  logic       sync_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] phase_cnt;
  logic       phase0;
  logic       locked;
  logic       sync_err;
  logic [7:0] err_cnt;

  int total = 0;
  int bad = 0;
  int p0_cnt = 0;

  hqm_rcfwl_gclk_pll_sync_rcvr #(.PERIOD(8), .CNT_W(3), .LOCK_CNT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_sync_in (pll_sync_in),
    .sync_en     (sync_en),
    .err_clr     (err_clr),
    .phase_cnt   (phase_cnt),
    .phase0      (phase0),
    .locked      (locked),
    .sync_err    (sync_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic p);
    pll_sync_in = p;
    @(posedge clk);
    #1;
    if (phase0) p0_cnt++;
  endtask

  task automatic pulse2();
    step(1'b1);
    step(1'b0);
  endtask

  task automatic gap6();
    repeat (6) step(1'b0);
  endtask

  // Four on-time pulses from TRACK at phase 6 -> LOCKED, ends at phase 6.
  task automatic relock();
    repeat (4) begin
      pulse2();
      gap6();
    end
  endtask

  // Skip one pulse from LOCKED at phase 6 -> error, TRACK at phase 0.
  task automatic miss();
    step(1'b0);
    step(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; sync_en = 1'b0; err_clr = 1'b0;
    step(1'b0);
    step(1'b0);
    total++; if (phase_cnt !== 3'd0) begin bad++; $display("FAIL rst_phase got=%0d want=0", phase_cnt); end
    total++; if (phase0 !== 1'b0) begin bad++; $display("FAIL rst_phase0 got=%0b want=0", phase0); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%0b want=0", locked); end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_sync_err got=%0b want=0", sync_err); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err_cnt got=%0d want=0", err_cnt); end
    total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dut.state, ST_IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_acquire();
    sync_en = 1'b1;
    step(1'b0);
    total++; if (dut.state !== ST_ACQ) begin bad++; $display("FAIL acq_state got=%0d want=%0d", dut.state, ST_ACQ); end
    pulse2();
    total++; if (dut.state !== ST_TRACK) begin bad++; $display("FAIL track_state got=%0d want=%0d", dut.state, ST_TRACK); end
    total++; if (phase_cnt !== 3'd0 || phase0 !== 1'b1) begin bad++; $display("FAIL track_phase got=%0d/%0b want=0/1", phase_cnt, phase0); end
    gap6();
    total++; if (phase_cnt !== 3'd6) begin bad++; $display("FAIL track_count got=%0d want=6", phase_cnt); end
    repeat (3) begin
      pulse2();
      gap6();
    end
    step(1'b1);
    total++; if (locked !== 1'b0 || phase_cnt !== 3'd7) begin bad++; $display("FAIL prelock got=%0b/%0d want=0/7", locked, phase_cnt); end
    step(1'b0);
    total++; if (locked !== 1'b1 || phase0 !== 1'b1) begin bad++; $display("FAIL lock got=%0b/%0b want=1/1", locked, phase0); end
    gap6();
    p0_cnt = 0;
    pulse2();
    gap6();
    total++; if (p0_cnt != 1) begin bad++; $display("FAIL phase0_rate got=%0d want=1", p0_cnt); end
    total++; if (sync_err !== 1'b0 || locked !== 1'b1) begin bad++; $display("FAIL steady got=%0b/%0b want=0/1", sync_err, locked); end
  endtask

  task automatic test_early();
    pulse2();
    repeat (4) step(1'b0);
    step(1'b1);
    total++; if (locked !== 1'b1 || phase_cnt !== 3'd5) begin bad++; $display("FAIL early_pre got=%0b/%0d want=1/5", locked, phase_cnt); end
    step(1'b0);
    total++; if (sync_err !== 1'b1 || err_cnt !== 8'd1) begin bad++; $display("FAIL early_err got=%0b/%0d want=1/1", sync_err, err_cnt); end
    total++; if (locked !== 1'b0 || phase_cnt !== 3'd0) begin bad++; $display("FAIL early_realign got=%0b/%0d want=0/0", locked, phase_cnt); end
    gap6();
    repeat (3) begin
      pulse2();
      gap6();
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL early_relock3 got=%0b want=0", locked); end
    pulse2();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL early_relock4 got=%0b want=1", locked); end
    gap6();
  endtask

  task automatic test_missed();
    step(1'b0);
    total++; if (locked !== 1'b1 || phase_cnt !== 3'd7) begin bad++; $display("FAIL miss_pre got=%0b/%0d want=1/7", locked, phase_cnt); end
    step(1'b0);
    total++; if (locked !== 1'b0 || sync_err !== 1'b1 || err_cnt !== 8'd2 || phase_cnt !== 3'd0) begin
      bad++; $display("FAIL miss_err got=%0b/%0b/%0d/%0d want=0/1/2/0", locked, sync_err, err_cnt, phase_cnt);
    end
    gap6();
  endtask

  task automatic test_err_clr();
    repeat (3) begin
      relock();
      miss();
      gap6();
    end
    relock();
    total++; if (locked !== 1'b1 || err_cnt !== 8'd5) begin bad++; $display("FAIL clr_setup got=%0b/%0d want=1/5", locked, err_cnt); end
    step(1'b0);
    err_clr = 1'b1;
    step(1'b0);
    total++; if (sync_err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
      bad++; $display("FAIL clr_collide got=%0b/%0d/%0b want=1/1/0", sync_err, err_cnt, locked);
    end
    step(1'b0);
    total++; if (sync_err !== 1'b0 || err_cnt !== 8'd0) begin bad++; $display("FAIL clr_alone got=%0b/%0d want=0/0", sync_err, err_cnt); end
    err_clr = 1'b0;
    repeat (5) step(1'b0);
  endtask

  task automatic test_saturate();
    for (int k = 1; k <= 300; k++) begin
      relock();
      miss();
      gap6();
      if (k == 254 || k == 255 || k == 256 || k == 300) begin
        total++;
        if (err_cnt !== ((k > 255) ? 8'd255 : 8'(k))) begin
          bad++; $display("FAIL sat_%0d got=%0d want=%0d", k, err_cnt, (k > 255) ? 255 : k);
        end
      end
    end
  endtask

  task automatic test_sync_en();
    sync_en = 1'b0;
    step(1'b1);
    total++; if (dut.state !== ST_IDLE || phase_cnt !== 3'd0 || phase0 !== 1'b0) begin
      bad++; $display("FAIL en_drop got=%0d/%0d/%0b want=%0d/0/0", dut.state, phase_cnt, phase0, ST_IDLE);
    end
    total++; if (sync_err !== 1'b1 || err_cnt !== 8'd255 || locked !== 1'b0) begin
      bad++; $display("FAIL en_retain got=%0b/%0d/%0b want=1/255/0", sync_err, err_cnt, locked);
    end
    step(1'b1);
    total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL en_idle got=%0d want=%0d", dut.state, ST_IDLE); end
    sync_en = 1'b1;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    total++; if (dut.state !== ST_ACQ || phase0 !== 1'b0) begin bad++; $display("FAIL en_one_rise got=%0d/%0b want=%0d/0", dut.state, phase0, ST_ACQ); end
    pulse2();
    total++; if (dut.state !== ST_TRACK || phase0 !== 1'b1 || sync_err !== 1'b1) begin
      bad++; $display("FAIL en_reacq got=%0d/%0b/%0b want=%0d/1/1", dut.state, phase0, sync_err, ST_TRACK);
    end
  endtask

  task automatic test_mid_reset();
    err_clr = 1'b1;
    step(1'b0);
    err_clr = 1'b0;
    repeat (5) step(1'b0);
    repeat (3) begin
      relock();
      miss();
      gap6();
    end
    relock();
    total++; if (locked !== 1'b1 || err_cnt !== 8'd3) begin bad++; $display("FAIL rst2_setup got=%0b/%0d want=1/3", locked, err_cnt); end
    rst = 1'b1;
    step(1'b1);
    total++; if (phase_cnt !== 3'd0 || phase0 !== 1'b0 || locked !== 1'b0 || sync_err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL rst2_outs got=%0d/%0b/%0b/%0b/%0d want=0/0/0/0/0", phase_cnt, phase0, locked, sync_err, err_cnt);
    end
    total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL rst2_state got=%0d want=%0d", dut.state, ST_IDLE); end
    rst = 1'b0;
    step(1'b1);
    total++; if (dut.state !== ST_ACQ) begin bad++; $display("FAIL rst2_acq got=%0d want=%0d", dut.state, ST_ACQ); end
    step(1'b0);
    total++; if (dut.state !== ST_TRACK || phase0 !== 1'b1) begin bad++; $display("FAIL rst2_held_rise got=%0d/%0b want=%0d/1", dut.state, phase0, ST_TRACK); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_early();
    test_missed();
    test_err_clr();
    test_saturate();
    test_sync_en();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
